// File: rtl/wb_arb_pkg.sv
// Shared constants for the writeback arbiter: default sizing and source numbering.
package wb_arb_pkg;

  localparam int NUM_SRC_DEF  = 5;
  localparam int NUM_PORT_DEF = 2;
  localparam int DATA_W_DEF   = 32;
  localparam int TAG_W_DEF    = 6;
  localparam int SRC_SEL_W    = 3;

  typedef enum logic [SRC_SEL_W-1:0] {
    SRC_ALU1   = 3'd0,
    SRC_ALU2   = 3'd1,
    SRC_LDST   = 3'd2,
    SRC_MUL    = 3'd3,
    SRC_BRANCH = 3'd4
  } src_id_e;

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: grants up to NUM_PORT requests scanning from rr_ptr, wrapping.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int NUM_PORT = NUM_PORT_DEF
) (
  input  logic [NUM_SRC-1:0]            req,
  input  logic [SRC_SEL_W-1:0]          rr_ptr,
  output logic [NUM_PORT*NUM_SRC-1:0]   port_oh,
  output logic [NUM_PORT*SRC_SEL_W-1:0] port_idx,
  output logic [NUM_PORT-1:0]           port_vld,
  output logic [NUM_SRC-1:0]            gnt,
  output logic [SRC_SEL_W-1:0]          next_ptr
);

  localparam int unsigned NS = NUM_SRC;
  localparam int unsigned NP = NUM_PORT;

  always_comb begin
    int unsigned          cnt;
    int unsigned          idx;
    logic [SRC_SEL_W-1:0] last;
    port_oh  = '0;
    port_idx = '0;
    port_vld = '0;
    gnt      = '0;
    last     = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NS) idx = idx - NS;
      if (req[idx] && (cnt < NP)) begin
        port_oh[cnt*NS + idx]                  = 1'b1;
        port_idx[cnt*SRC_SEL_W +: SRC_SEL_W]   = SRC_SEL_W'(idx);
        port_vld[cnt]                          = 1'b1;
        gnt[idx]                               = 1'b1;
        last                                   = SRC_SEL_W'(idx);
        cnt                                    = cnt + 1;
      end
    end
    if (cnt == 0)
      next_ptr = rr_ptr;
    else if (last == SRC_SEL_W'(NS - 1))
      next_ptr = '0;
    else
      next_ptr = last + 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry buffer per execution unit, round-robin onto NUM_PORT write ports.
// Optional WB_ARB_STATS_EN adds stall_cnt_o (saturating count of cycles leaving a buffer ungranted).
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int NUM_PORT = NUM_PORT_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          kill_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*TAG_W-1:0]      src_tag_i,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  output logic [NUM_PORT-1:0]           wb_we_o,
  output logic [NUM_PORT*TAG_W-1:0]     wb_tag_o,
  output logic [NUM_PORT*DATA_W-1:0]    wb_data_o,
  output logic [NUM_PORT*SRC_SEL_W-1:0] wb_src_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int unsigned NS = NUM_SRC;
  localparam int unsigned NP = NUM_PORT;

  logic [NUM_SRC-1:0]            buf_v;
  logic [TAG_W-1:0]              buf_tag  [NUM_SRC];
  logic [DATA_W-1:0]             buf_data [NUM_SRC];
  logic [SRC_SEL_W-1:0]          rr_ptr;
  logic [SRC_SEL_W-1:0]          next_ptr;
  logic [NUM_PORT*NUM_SRC-1:0]   port_oh;
  logic [NUM_PORT*SRC_SEL_W-1:0] port_idx;
  logic [NUM_PORT-1:0]           port_vld;
  logic [NUM_SRC-1:0]            gnt;
  logic [NUM_SRC-1:0]            accept;

  wb_rr_picker #(
    .NUM_SRC  (NUM_SRC),
    .NUM_PORT (NUM_PORT)
  ) u_picker (
    .req      (buf_v),
    .rr_ptr   (rr_ptr),
    .port_oh  (port_oh),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  // A granted buffer drains this cycle, so it can refill in the same cycle.
  assign src_ready_o = {NUM_SRC{~kill_i}} & (~buf_v | gnt);
  assign accept      = src_valid_i & src_ready_o;

  assign wb_we_o  = port_vld & {NUM_PORT{~kill_i}};
  assign wb_src_o = port_idx;

  always_comb begin
    wb_tag_o  = '0;
    wb_data_o = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (port_oh[p*NS + i]) begin
          wb_tag_o[p*TAG_W +: TAG_W]    |= buf_tag[i];
          wb_data_o[p*DATA_W +: DATA_W] |= buf_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_v  <= '0;
      rr_ptr <= '0;
    end else if (kill_i) begin
      buf_v  <= '0;
    end else begin
      buf_v  <= (buf_v & ~gnt) | accept;
      rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NS; i++) begin
      if (accept[i]) begin
        buf_tag[i]  <= src_tag_i[i*TAG_W +: TAG_W];
        buf_data[i] <= src_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic stall;
  assign stall = (|(buf_v & ~gnt)) & ~kill_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default sizing: 5 sources, 2 ports).
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int NS = 5;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int TW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              kill;
  logic [NS-1:0]     src_valid;
  logic [NS*TW-1:0]  src_tag;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic [NP-1:0]     wb_we;
  logic [NP*TW-1:0]  wb_tag;
  logic [NP*DW-1:0]  wb_data;
  logic [NP*3-1:0]   wb_src;
`ifdef WB_ARB_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_SRC  (NS),
    .NUM_PORT (NP),
    .DATA_W   (DW),
    .TAG_W    (TW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .kill_i      (kill),
    .src_valid_i (src_valid),
    .src_tag_i   (src_tag),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .wb_we_o     (wb_we),
    .wb_tag_o    (wb_tag),
    .wb_data_o   (wb_data),
    .wb_src_o    (wb_src)
`ifdef WB_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i]         = 1'b1;
    src_tag[i*TW +: TW]  = t;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic idle;
    src_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    kill      = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;
    #2;
    check("rst_we",    wb_we,     2'b00);
    check("rst_tag",   wb_tag,    12'h000);
    check("rst_data",  wb_data,   64'h0);
    check("rst_src",   wb_src,    6'o00);
    check("rst_ready", src_ready, 5'h1f);
`ifdef WB_ARB_STATS_EN
    check("rst_stall", stall_cnt, 32'd0);
`endif
    step;
    rst_n = 1'b1;

    // single ALU1 result
    step; drive(SRC_ALU1, 6'h05, 32'hDEAD_BEEF); #1;
    check("t1_ready_in", src_ready, 5'h1f);
    step; idle; #1;
    check("t1_we",    wb_we,   2'b01);
    check("t1_tag",   wb_tag,  12'h005);
    check("t1_data",  wb_data, {32'h0, 32'hDEAD_BEEF});
    check("t1_src",   wb_src,  {3'd0, 3'd0});
    check("t1_ready", src_ready, 5'h1f);

    // BRANCH alone from ptr=1 -> grant 4, ptr wraps to 0
    step; drive(SRC_BRANCH, 6'h3f, 32'h1234_5678); #1;
    step; idle; #1;
    check("wrap_we",  wb_we,  2'b01);
    check("wrap_src", wb_src, {3'd0, 3'd4});
    check("wrap_tag", wb_tag, 12'h03f);

    // all five at once, ptr=0
    step;
    for (int i = 0; i < NS; i++) drive(i, 6'(10 + i), 32'(100 + i));
    #1;
    check("all_ready_in", src_ready, 5'h1f);
    step; idle; #1;
    check("all1_we",    wb_we,     2'b11);
    check("all1_src",   wb_src,    {3'd1, 3'd0});
    check("all1_tag",   wb_tag,    {6'd11, 6'd10});
    check("all1_data",  wb_data,   {32'd101, 32'd100});
    check("all1_ready", src_ready, 5'b00011);
    step; #1;
    check("all2_we",    wb_we,     2'b11);
    check("all2_src",   wb_src,    {3'd3, 3'd2});
    check("all2_tag",   wb_tag,    {6'd13, 6'd12});
    check("all2_ready", src_ready, 5'b01111);
    step; #1;
    check("all3_we",    wb_we,     2'b01);
    check("all3_src",   wb_src,    {3'd0, 3'd4});
    check("all3_tag",   wb_tag,    {6'd0, 6'd14});
    check("all3_data",  wb_data,   {32'd0, 32'd104});
    check("all3_ready", src_ready, 5'h1f);
`ifdef WB_ARB_STATS_EN
    check("all3_stall", stall_cnt, 32'd2);
`endif
    step; #1;
    check("idle_we", wb_we, 2'b00);

    // LDST alone from ptr=0 -> ptr=3
    step; drive(SRC_LDST, 6'h22, 32'h0000_000a); #1;
    step; idle; #1;
    check("ldst_src", wb_src, {3'd0, 3'd2});

    // sources 3,4 with ptr=3 -> both granted, ptr wraps to 0
    step; drive(SRC_MUL, 6'h23, 32'h0000_0023); drive(SRC_BRANCH, 6'h24, 32'h0000_0024); #1;
    step; idle; #1;
    check("p3_we",  wb_we,  2'b11);
    check("p3_src", wb_src, {3'd4, 3'd3});
    check("p3_tag", wb_tag, {6'h24, 6'h23});

    // 0 and 4 with ptr=0 -> port0=0, port1=4
    step; drive(SRC_ALU1, 6'h30, 32'h0000_0030); drive(SRC_BRANCH, 6'h34, 32'h0000_0034); #1;
    step; idle; #1;
    check("p0_src", wb_src, {3'd4, 3'd0});
    check("p0_tag", wb_tag, {6'h34, 6'h30});

    // ALU1 every cycle: no bubbles after the first
    for (int k = 0; k < 5; k++) begin
      step; drive(SRC_ALU1, 6'(6'h10 + k), 32'(32'h100 + k)); #1;
      check("sus_ready", src_ready[0], 1'b1);
      if (k == 0) begin
        check("sus_we0", wb_we, 2'b00);
      end else begin
        check("sus_we",  wb_we, 2'b01);
        check("sus_tag", wb_tag, {6'h0, 6'(6'h10 + k - 1)});
      end
    end
    step; idle; #1;
    check("sus_last_we",  wb_we,  2'b01);
    check("sus_last_tag", wb_tag, 12'h014);

    // kill with three buffers full (ptr=1)
    step; drive(0, 6'h40, 32'h40); drive(1, 6'h41, 32'h41); drive(2, 6'h42, 32'h42); #1;
    step; idle; kill = 1'b1; #1;
    check("kill_we",    wb_we,     2'b00);
    check("kill_ready", src_ready, 5'b00000);
    step; kill = 1'b0; drive(0, 6'h50, 32'h50); drive(1, 6'h51, 32'h51); #1;
    check("pk_we",    wb_we,     2'b00);
    check("pk_ready", src_ready, 5'h1f);
    step; idle; #1;
    check("pk_grant_we",  wb_we,  2'b11);
    check("pk_grant_src", wb_src, {3'd0, 3'd1});
    check("pk_grant_tag", wb_tag, {6'h50, 6'h51});

    // asynchronous reset mid-stream with all buffers full (ptr=1)
    step;
    for (int i = 0; i < NS; i++) drive(i, 6'(6'h20 + i), 32'(32'h600 + i));
    #1;
    step; idle; #1;
    check("mid_we",    wb_we,     2'b11);
    check("mid_src",   wb_src,    {3'd2, 3'd1});
    check("mid_ready", src_ready, 5'b00110);
`ifdef WB_ARB_STATS_EN
    check("mid_stall", stall_cnt, 32'd2);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we",    wb_we,     2'b00);
    check("arst_tag",   wb_tag,    12'h000);
    check("arst_data",  wb_data,   64'h0);
    check("arst_src",   wb_src,    6'o00);
    check("arst_ready", src_ready, 5'h1f);
`ifdef WB_ARB_STATS_EN
    check("arst_stall", stall_cnt, 32'd0);
`endif
    step;
    rst_n = 1'b1;
    step; #1;
    check("post_we", wb_we, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
